// File: rtl/ttl_mailbox_pkg.sv
// Shared types and counter widths for the latch mailbox sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ttl_mailbox_pkg;

  // Sequencer states for one latch write/ack cycle
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_PENDING = 2'd3
  } mbx_state_t;

  // Phase counter covers SETUP/STROBE lengths up to 15 cycles
  localparam int PHASE_W  = 4;
  // Retrigger counter covers intervals up to 65535 cycles
  localparam int RETRIG_W = 16;

endpackage

// File: rtl/ttl_latch_mailbox_ctrl_if.sv
// Bundles the CPU strobes, latch pins and status lines of the mailbox.
// Latency: none (wiring only).
// Backpressure: none; strobes are edge-based, status is level-based.
interface ttl_latch_mailbox_ctrl_if #(
  parameter int WIDTH = 6
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic             clr;
  logic [WIDTH-1:0] lat_q;
  logic [WIDTH-1:0] lat_d;
  logic             lat_clk;
  logic             lat_resetn;
  logic [WIDTH-1:0] rd_data;
  logic             irq_n;
  logic             pending;
  logic             overrun;
  logic             busy;

  // Environment side: CPUs and the physical latch
  modport master (
    output wr_req, wr_data, rd_req, clr, lat_q,
    input  lat_d, lat_clk, lat_resetn, rd_data, irq_n, pending, overrun, busy
  );

  // Sequencer side
  modport slave (
    input  wr_req, wr_data, rd_req, clr, lat_q,
    output lat_d, lat_clk, lat_resetn, rd_data, irq_n, pending, overrun, busy
  );
endinterface

// File: rtl/ttl_strobe_edge.sv
// Registered rising-edge detector for a level CPU strobe.
// Latency: edge is combinational against the registered previous level.
// Backpressure: none; a strobe already high when reset releases is not an edge.
module ttl_strobe_edge (
  input  logic Clk,
  input  logic RESETn,
  input  logic i_lvl,
  output logic o_edge
);
  logic r_prev;
  logic r_armed;

  // Remember the previous level; the first clock after reset only primes history
  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_lvl;
      r_armed <= 1'b1;
    end
  end

  assign o_edge = i_lvl & ~r_prev & r_armed;
endmodule

// File: rtl/ttl_latch_mailbox_ctrl.sv
// Drives an external hex D latch as a CPU-to-CPU command mailbox with irq and status.
// Latency: write edge to lat_clk rise is 1+SETUP_CYC cycles; all outputs registered.
// Backpressure: writes while busy/pending set sticky overrun; newest pending value wins.
module ttl_latch_mailbox_ctrl
  import ttl_mailbox_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int RETRIG_CYC = 0
) (
  input  logic                     Clk,
  input  logic                     RESETn,
  ttl_latch_mailbox_ctrl_if.slave  mbx
);
  localparam logic [PHASE_W-1:0]  SETUP_LIM  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0]  STROBE_LIM = PHASE_W'(STROBE_CYC - 1);
  localparam bit                  RETRIG_EN  = (RETRIG_CYC > 0);
  localparam logic [RETRIG_W-1:0] RETRIG_LIM = RETRIG_W'((RETRIG_CYC > 0) ? RETRIG_CYC - 1 : 0);

  mbx_state_t          r_state, w_state_nxt;
  logic [PHASE_W-1:0]  r_cnt, w_cnt_nxt;
  logic [RETRIG_W-1:0] r_rcnt, w_rcnt_nxt;
  logic [WIDTH-1:0]    r_lat_d, w_lat_d_nxt;
  logic [WIDTH-1:0]    r_rd_data, w_rd_data_nxt;
  logic                r_lat_clk, w_lat_clk_nxt;
  logic                r_lat_resetn, w_lat_resetn_nxt;
  logic                r_irq_n, w_irq_n_nxt;
  logic                r_pending, w_pending_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_wr_edge, w_rd_edge;

  ttl_strobe_edge u_wr_edge (.Clk(Clk), .RESETn(RESETn), .i_lvl(mbx.wr_req), .o_edge(w_wr_edge));
  ttl_strobe_edge u_rd_edge (.Clk(Clk), .RESETn(RESETn), .i_lvl(mbx.rd_req), .o_edge(w_rd_edge));

  // State and output registers; latch clear is held while RESETn is low
  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rcnt       <= '0;
      r_lat_d      <= '0;
      r_rd_data    <= '0;
      r_lat_clk    <= 1'b0;
      r_lat_resetn <= 1'b0;
      r_irq_n      <= 1'b1;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_lat_d      <= w_lat_d_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_lat_clk    <= w_lat_clk_nxt;
      r_lat_resetn <= w_lat_resetn_nxt;
      r_irq_n      <= w_irq_n_nxt;
      r_pending    <= w_pending_nxt;
      r_overrun    <= w_overrun_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; soft clear overrides every state
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rcnt_nxt       = r_rcnt;
    w_lat_d_nxt      = r_lat_d;
    w_rd_data_nxt    = r_rd_data;
    w_lat_clk_nxt    = r_lat_clk;
    w_lat_resetn_nxt = 1'b1;
    w_irq_n_nxt      = r_irq_n;
    w_pending_nxt    = r_pending;
    w_overrun_nxt    = r_overrun;
    w_busy_nxt       = r_busy;
    if (mbx.clr) begin
      w_state_nxt      = ST_IDLE;
      w_cnt_nxt        = '0;
      w_rcnt_nxt       = '0;
      w_lat_clk_nxt    = 1'b0;
      w_lat_resetn_nxt = 1'b0;
      w_irq_n_nxt      = 1'b1;
      w_pending_nxt    = 1'b0;
      w_overrun_nxt    = 1'b0;
      w_busy_nxt       = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_edge) w_rd_data_nxt = mbx.lat_q;
          if (w_wr_edge) begin
            w_lat_d_nxt = mbx.wr_data;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_rd_edge) w_rd_data_nxt = mbx.lat_q;
          if (w_wr_edge) w_overrun_nxt = 1'b1;
          if (r_cnt == SETUP_LIM) begin
            w_state_nxt   = ST_STROBE;
            w_cnt_nxt     = '0;
            w_lat_clk_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (w_rd_edge) w_rd_data_nxt = mbx.lat_q;
          if (w_wr_edge) w_overrun_nxt = 1'b1;
          if (r_cnt == STROBE_LIM) begin
            w_state_nxt   = ST_PENDING;
            w_cnt_nxt     = '0;
            w_rcnt_nxt    = '0;
            w_lat_clk_nxt = 1'b0;
            w_pending_nxt = 1'b1;
            w_irq_n_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_PENDING: begin
          // A read in the same cycle as a write retires the old command first
          if (w_rd_edge) begin
            w_rd_data_nxt = mbx.lat_q;
            w_irq_n_nxt   = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end
          if (w_wr_edge) begin
            w_lat_d_nxt = mbx.wr_data;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
            if (!w_rd_edge) begin
              w_overrun_nxt = 1'b1;
              w_irq_n_nxt   = 1'b0;
            end
          end
          if (RETRIG_EN && !w_rd_edge && !w_wr_edge) begin
            if (r_rcnt == RETRIG_LIM) begin
              w_irq_n_nxt = 1'b1;
              w_rcnt_nxt  = '0;
            end else begin
              w_irq_n_nxt = 1'b0;
              w_rcnt_nxt  = r_rcnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign mbx.lat_d      = r_lat_d;
  assign mbx.lat_clk    = r_lat_clk;
  assign mbx.lat_resetn = r_lat_resetn;
  assign mbx.rd_data    = r_rd_data;
  assign mbx.irq_n      = r_irq_n;
  assign mbx.pending    = r_pending;
  assign mbx.overrun    = r_overrun;
  assign mbx.busy       = r_busy;
endmodule

// File: tb/tb_ttl_latch_mailbox_ctrl.sv
// Self-checking bench: directed mailbox scenarios plus random write/read transactions.
// Latency: expectations derived from setup/strobe/retrigger cycle counts.
// Backpressure: overrun expectations follow the busy/pending write rules.
module tb_ttl_latch_mailbox_ctrl;
  localparam int W  = 6;
  localparam int SC = 1;
  localparam int TC = 2;
  localparam int RC = 100;

  logic Clk;
  logic RESETn;
  int   checks;
  int   failures;

  ttl_latch_mailbox_ctrl_if #(.WIDTH(W)) if0 ();
  ttl_latch_mailbox_ctrl_if #(.WIDTH(W)) if1 ();

  ttl_latch_mailbox_ctrl #(.WIDTH(W), .SETUP_CYC(SC), .STROBE_CYC(TC), .RETRIG_CYC(0))
    dut0 (.Clk(Clk), .RESETn(RESETn), .mbx(if0.slave));
  ttl_latch_mailbox_ctrl #(.WIDTH(W), .SETUP_CYC(SC), .STROBE_CYC(TC), .RETRIG_CYC(RC))
    dut1 (.Clk(Clk), .RESETn(RESETn), .mbx(if1.slave));

  // The retrigger instance sees exactly the same CPU stimulus
  assign if1.wr_req  = if0.wr_req;
  assign if1.wr_data = if0.wr_data;
  assign if1.rd_req  = if0.rd_req;
  assign if1.clr     = if0.clr;

  // Physical hex latches: capture D on clock rise, async clear
  logic [W-1:0] lq0, lq1;
  always @(posedge if0.lat_clk or negedge if0.lat_resetn)
    if (!if0.lat_resetn) lq0 <= '0; else lq0 <= if0.lat_d;
  always @(posedge if1.lat_clk or negedge if1.lat_resetn)
    if (!if1.lat_resetn) lq1 <= '0; else lq1 <= if1.lat_d;
  assign if0.lat_q = lq0;
  assign if1.lat_q = lq1;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a completed latch write: pending with no sequence in flight
  task automatic wait_pending();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if0.pending && !if0.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_pending", {31'd0, ok}, 32'd1);
  endtask

  task automatic wr_pulse(input logic [W-1:0] d);
    if0.wr_data = d;
    if0.wr_req  = 1'b1;
    tick();
    if0.wr_req  = 1'b0;
  endtask

  task automatic rd_pulse();
    if0.rd_req = 1'b1;
    tick();
    if0.rd_req = 1'b0;
  endtask

  logic [W-1:0] exp_val, d1, d2;
  logic         exp_ovr;
  int           mode;

  initial begin
    checks   = 0;
    failures = 0;
    RESETn      = 1'b0;
    if0.wr_req  = 1'b1;
    if0.wr_data = 6'h2A;
    if0.rd_req  = 1'b0;
    if0.clr     = 1'b0;

    // Reset state with wr_req already high
    repeat (3) tick();
    chk("rst_lat_resetn", {31'd0, if0.lat_resetn}, 32'd0);
    chk("rst_lat_d", {26'd0, if0.lat_d}, 32'd0);
    chk("rst_lat_clk", {31'd0, if0.lat_clk}, 32'd0);
    chk("rst_rd_data", {26'd0, if0.rd_data}, 32'd0);
    chk("rst_irq_n", {31'd0, if0.irq_n}, 32'd1);
    chk("rst_pending", {31'd0, if0.pending}, 32'd0);
    chk("rst_overrun", {31'd0, if0.overrun}, 32'd0);
    chk("rst_busy", {31'd0, if0.busy}, 32'd0);
    RESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rel_lat_resetn", {31'd0, if0.lat_resetn}, 32'd1);
      chk("rel_busy", {31'd0, if0.busy}, 32'd0);
      chk("rel_lat_clk", {31'd0, if0.lat_clk}, 32'd0);
      chk("rel_pending", {31'd0, if0.pending}, 32'd0);
    end
    chk("rel_lat_q", {26'd0, if0.lat_q}, 32'd0);
    if0.wr_req = 1'b0;
    tick();

    // Basic write 2A: cycle-exact waveform
    if0.wr_data = 6'h2A;
    if0.wr_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) if0.wr_req = 1'b0;
      chk("w1_lat_d", {26'd0, if0.lat_d}, 32'h2A);
      chk("w1_lat_clk", {31'd0, if0.lat_clk}, {31'd0, (k > SC && k <= SC + TC)});
      chk("w1_busy", {31'd0, if0.busy}, {31'd0, (k <= SC + TC)});
      chk("w1_pending", {31'd0, if0.pending}, {31'd0, (k > SC + TC)});
      chk("w1_irq_n", {31'd0, if0.irq_n}, {31'd0, (k <= SC + TC)});
    end
    chk("w1_lat_q", {26'd0, if0.lat_q}, 32'h2A);
    rd_pulse();
    chk("r1_rd_data", {26'd0, if0.rd_data}, 32'h2A);
    chk("r1_irq_n", {31'd0, if0.irq_n}, 32'd1);
    chk("r1_pending", {31'd0, if0.pending}, 32'd0);
    tick();

    // Write during STROBE is ignored but flags overrun
    wr_pulse(6'h2A);
    tick();
    wr_pulse(6'h15);
    chk("ws_overrun", {31'd0, if0.overrun}, 32'd1);
    chk("ws_busy", {31'd0, if0.busy}, 32'd1);
    wait_pending();
    chk("ws_lat_q", {26'd0, if0.lat_q}, 32'h2A);
    chk("ws_lat_d", {26'd0, if0.lat_d}, 32'h2A);

    // Write while PENDING replaces the value, irq stays asserted
    wr_pulse(6'h15);
    chk("wp_irq_n", {31'd0, if0.irq_n}, 32'd0);
    chk("wp_pending", {31'd0, if0.pending}, 32'd1);
    chk("wp_lat_d", {26'd0, if0.lat_d}, 32'h15);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        chk("wp_irq_hold", {31'd0, if0.irq_n}, 32'd0);
        if (!if0.busy) begin
          ok = 1'b1;
          break;
        end
      end
      chk("wp_done", {31'd0, ok}, 32'd1);
    end
    chk("wp_lat_q", {26'd0, if0.lat_q}, 32'h15);
    chk("wp_overrun", {31'd0, if0.overrun}, 32'd1);
    rd_pulse();
    chk("r2_rd_data", {26'd0, if0.rd_data}, 32'h15);
    tick();

    // Soft clear mid-SETUP aborts the sequence
    wr_pulse(6'h3C);
    if0.clr = 1'b1;
    tick();
    if0.clr = 1'b0;
    chk("clr_lat_resetn", {31'd0, if0.lat_resetn}, 32'd0);
    chk("clr_lat_clk", {31'd0, if0.lat_clk}, 32'd0);
    chk("clr_pending", {31'd0, if0.pending}, 32'd0);
    chk("clr_irq_n", {31'd0, if0.irq_n}, 32'd1);
    chk("clr_overrun", {31'd0, if0.overrun}, 32'd0);
    chk("clr_busy", {31'd0, if0.busy}, 32'd0);
    chk("clr_rd_data", {26'd0, if0.rd_data}, 32'h15);
    chk("clr_lat_q", {26'd0, if0.lat_q}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("clr_after_clk", {31'd0, if0.lat_clk}, 32'd0);
      chk("clr_after_busy", {31'd0, if0.busy}, 32'd0);
      chk("clr_after_resetn", {31'd0, if0.lat_resetn}, 32'd1);
    end

    // Same-cycle read and write in PENDING: read retires old value first
    wr_pulse(6'h0A);
    wait_pending();
    chk("sc_lat_q0", {26'd0, if0.lat_q}, 32'h0A);
    if0.wr_data = 6'h33;
    if0.wr_req  = 1'b1;
    if0.rd_req  = 1'b1;
    tick();
    if0.wr_req  = 1'b0;
    if0.rd_req  = 1'b0;
    chk("sc_rd_data", {26'd0, if0.rd_data}, 32'h0A);
    chk("sc_overrun", {31'd0, if0.overrun}, 32'd0);
    chk("sc_pending", {31'd0, if0.pending}, 32'd0);
    chk("sc_irq_n", {31'd0, if0.irq_n}, 32'd1);
    chk("sc_busy", {31'd0, if0.busy}, 32'd1);
    wait_pending();
    chk("sc_lat_q1", {26'd0, if0.lat_q}, 32'h33);
    chk("sc_overrun2", {31'd0, if0.overrun}, 32'd0);
    rd_pulse();
    tick();

    // Retrigger: irq_n re-pulses every RC cycles on the retrigger instance only
    wr_pulse(6'h2A);
    wait_pending();
    chk("rt_pending1", {31'd0, if1.pending}, 32'd1);
    for (int n = 1; n <= 205; n++) begin
      tick();
      chk("rt_irq1", {31'd0, if1.irq_n}, {31'd0, (n % RC == 0)});
      chk("rt_irq0", {31'd0, if0.irq_n}, 32'd0);
    end
    rd_pulse();
    chk("rt_ack_irq1", {31'd0, if1.irq_n}, 32'd1);
    chk("rt_rd_data1", {26'd0, if1.rd_data}, 32'h2A);
    tick();

    // Random transactions against a transaction-level mailbox model
    if0.clr = 1'b1;
    tick();
    if0.clr = 1'b0;
    tick();
    exp_val = '0;
    exp_ovr = 1'b0;
    for (int it = 0; it < 20; it++) begin
      d1   = W'($urandom_range(0, 63));
      d2   = W'($urandom_range(0, 63));
      mode = $urandom_range(0, 2);
      wr_pulse(d1);
      exp_val = d1;
      if (mode == 1) begin
        tick();
        wr_pulse(d2);
        exp_ovr = 1'b1;
      end
      wait_pending();
      if (mode == 2) begin
        wr_pulse(d2);
        exp_val = d2;
        exp_ovr = 1'b1;
        wait_pending();
      end
      chk("rnd_lat_q", {26'd0, if0.lat_q}, {26'd0, exp_val});
      chk("rnd_overrun", {31'd0, if0.overrun}, {31'd0, exp_ovr});
      chk("rnd_irq_n", {31'd0, if0.irq_n}, 32'd0);
      rd_pulse();
      chk("rnd_rd_data", {26'd0, if0.rd_data}, {26'd0, exp_val});
      chk("rnd_pending", {31'd0, if0.pending}, 32'd0);
      tick();
      repeat ($urandom_range(0, 3)) tick();
      rd_pulse();
      chk("rnd_idle_rd", {26'd0, if0.rd_data}, {26'd0, exp_val});
      chk("rnd_idle_pend", {31'd0, if0.pending}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ttl_latch_mailbox_ctrl.md
Name: ttl_latch_mailbox_ctrl

Overview:
Sequencer that owns one external hex D latch (6-bit, positive-edge clocked, async active-low clear) used as a main-CPU→sound-CPU command mailbox. It converts CPU write/read strobes into correctly timed latch D/clock/clear waveforms, raises an interrupt to the sound CPU, and tracks pending and overrun status. It sits between the main-CPU address decode and the sound-CPU interrupt/read path.

Parameters:
WIDTH, 6, latch data width (one hex latch)
SETUP_CYC, 1, Clk cycles lat_d is stable before lat_clk rises (1..15)
STROBE_CYC, 2, Clk cycles lat_clk is held high (1..15)
RETRIG_CYC, 0, cycles in PENDING before irq_n is re-pulsed; 0 disables retrigger (else 2..65535)

Ports:
Clk  in  1  system clock
RESETn  in  1  reset, asynchronous, active-low
wr_req  in  1  main-CPU write strobe, level, active-high; rising edge = one write
wr_data  in  WIDTH  command value, sampled on the wr_req rising edge
rd_req  in  1  sound-CPU read strobe, level, active-high; rising edge = one read/ack
clr  in  1  soft clear, synchronous, 1-cycle pulse
lat_q  in  WIDTH  latch Q outputs
lat_d  out  WIDTH  latch D drive
lat_clk  out  1  latch clock drive
lat_resetn  out  1  latch clear drive, active-low
rd_data  out  WIDTH  value returned to sound CPU
irq_n  out  1  sound-CPU interrupt, active-low
pending  out  1  command written, not yet read
overrun  out  1  sticky: write arrived while busy or pending
busy  out  1  high in SETUP or STROBE

Behaviour:
- Reset (RESETn low, async): state IDLE; lat_d=0, lat_clk=0, lat_resetn=0 while RESETn low then 1 on the first clock after release; rd_data=0, irq_n=1, pending=0, overrun=0, busy=0; edge-detect history regs = 0 (a strobe already high at release is not an edge).
- Edge detect: registered previous value; edge = now & ~prev. All outputs registered.
- FSM states: IDLE, SETUP, STROBE, PENDING.
- IDLE: wr edge -> capture wr_data into lat_d, enter SETUP, busy=1.
- SETUP: lat_clk=0 for SETUP_CYC cycles, then STROBE.
- STROBE: lat_clk=1 for STROBE_CYC cycles; on exit lat_clk=0, pending=1, irq_n=0, busy=0, enter PENDING. wr_data→lat_q latency = 1+SETUP_CYC cycles to lat_clk rise.
- PENDING: rd edge -> rd_data<=lat_q, irq_n=1, pending=0, enter IDLE. wr edge -> overrun=1, new value captured, re-enter SETUP (irq_n stays 0, pending stays 1 until new STROBE completes; newest value wins).
- wr edge in SETUP/STROBE: ignored, overrun=1.
- rd edge outside PENDING: rd_data<=lat_q, no state change, no flag change.
- Same-cycle wr edge and rd edge in PENDING: read completes first (rd_data<=old lat_q, irq_n=1, pending=0), write starts SETUP; overrun not set.
- Retrigger (RETRIG_CYC>0): counter counts in PENDING, reset on entry; at RETRIG_CYC, irq_n=1 for exactly one cycle then 0, counter restarts. Counter never wraps silently.
- clr: highest priority after RESETn. lat_resetn=0 for one cycle, lat_clk=0, state IDLE, pending=0, irq_n=1, overrun=0, busy=0; any in-flight sequence aborted. rd_data unchanged.
- overrun cleared only by RESETn or clr.

Decomposition:
- Shared package ttl_mailbox_pkg: FSM state enum, counter width constants (4-bit phase counter, 16-bit retrigger counter).
- One sub-module natural: ttl_strobe_edge (registered rising-edge detector, reused for wr_req and rd_req).

Test Plan:
- Reset release with wr_req held high -> no latch sequence; all outputs at reset values; lat_resetn 0 during reset, 1 after.
- wr_req edge with wr_data=6'h2A (defaults) -> lat_d=2A next cycle, lat_clk high cycles 3–4, pending=1/irq_n=0 cycle 5; model latch lat_q=2A; rd edge -> rd_data=2A, irq_n=1, pending=0.
- Second write 6'h15 during STROBE -> ignored, overrun=1, lat_q remains 2A; write 6'h15 in PENDING -> overrun=1, lat_q becomes 15, irq_n held 0 throughout.
- Same-cycle rd and wr edges in PENDING (lat_q=0A, wr_data=33) -> rd_data=0A, overrun=0, then lat_q=33, pending=1.
- RETRIG_CYC=100, no read -> irq_n high for one cycle at 100 and 200 cycles after PENDING entry.
- clr mid-SETUP -> lat_resetn low one cycle, lat_clk never rises, pending=0, irq_n=1, overrun=0, state IDLE.
